seq_pattern_tx: RTL and testbench

Serial pattern transmitter. It is the source end of the serial bit-stream consumed by the team's Moore sequence detectors. It loads a W-bit pattern, shifts it out MSB-first one bit per clock, repeats it a programmable number of times with optional idle gaps, and signals completion. It is used to drive detector inputs (e.g. pattern 1010) in-system and on benches.

---
 rtl/seq_pattern_tx.sv | 165 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first, repeated frames with idle gaps
//
// Loads a W-bit pattern on an accepted start. Shifts it out one bit per clock,
// MSB first, for 'repeats' frames. Frames are separated by 'gap' idle cycles.
// A one-cycle done pulse follows the last frame.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      transfer request, sampled only in IDLE
//   abort_i      synchronous abort, acted on only in SHIFT/GAP
//   pattern_i    bits to send (MSB first), captured at accepted start
//   repeats_i    number of frames, captured at accepted start
//   gap_i        idle cycles between frames, captured at accepted start
//   y_o          serial data bit (registered)
//   valid_o      y_o carries a pattern bit this cycle (registered)
//   busy_o       transfer in progress (SHIFT or GAP)
//   done_o       one-cycle completion pulse
//   frame_cnt_o  frames fully sent in the current or last transfer
module seq_pattern_tx #(
   parameter int W     = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [W-1:0]     pattern_i,
   input  logic [CNT_W-1:0] repeats_i,
   input  logic [GAP_W-1:0] gap_i,
   output logic             y_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] frame_cnt_o
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       pat_q, pat_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [CNT_W-1:0]   fcnt_q, fcnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               y_q, y_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               last_bit;
   logic               more_frames;
   logic [CNT_W:0]     fcnt_inc;

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      rep_d    = rep_q;
      fcnt_d   = fcnt_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      idx_d    = idx_q;
      last_bit = (idx_q == IDX_LAST);
      fcnt_inc = {1'b0, fcnt_q} + {{CNT_W{1'b0}}, 1'b1};
      // Compared one bit wider so the test cannot wrap when repeats is all-ones.
      more_frames = (fcnt_inc < {1'b0, rep_q});

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pat_d   = pattern_i;
               rep_d   = repeats_i;
               gap_d   = gap_i;
               fcnt_d  = '0;
               idx_d   = '0;
               gcnt_d  = '0;
               state_d = (repeats_i != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            idx_d = idx_q + IW'(1);
            if (last_bit) begin
               idx_d  = '0;
               gcnt_d = '0;
               // A frame whose last bit went out counts as sent even if aborted on that edge.
               if (fcnt_q != {CNT_W{1'b1}}) begin
                  fcnt_d = fcnt_inc[CNT_W-1:0];
               end
               if (more_frames) begin
                  state_d = (gap_q != '0) ? S_GAP : S_SHIFT;
               end else begin
                  state_d = S_DONE;
               end
            end
            if (abort_i) begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gcnt_q == gap_q - GAP_W'(1)) begin
               state_d = S_SHIFT;
               idx_d   = '0;
            end else begin
               gcnt_d = gcnt_q + GAP_W'(1);
            end
            if (abort_i) begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they can be registered
      // and still line up with the state they describe.
      valid_d = (state_d == S_SHIFT);
      busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP);
      done_d  = (state_d == S_DONE);
      y_d     = (state_d == S_SHIFT) ? pat_d[IDX_LAST - idx_d] : 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         rep_q   <= '0;
         fcnt_q  <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         idx_q   <= '0;
         y_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rep_q   <= rep_d;
         fcnt_q  <= fcnt_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign y_o         = y_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

   localparam int W     = 4;
   localparam int CNT_W = 4;
   localparam int GAP_W = 4;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             start_i;
   logic             abort_i;
   logic [W-1:0]     pattern_i;
   logic [CNT_W-1:0] repeats_i;
   logic [GAP_W-1:0] gap_i;
   logic             y_o;
   logic             valid_o;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] frame_cnt_o;

   always #5 clk = ~clk;

   seq_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .pattern_i   (pattern_i),
      .repeats_i   (repeats_i),
      .gap_i       (gap_i),
      .y_o         (y_o),
      .valid_o     (valid_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .frame_cnt_o (frame_cnt_o)
   );

   typedef struct {
      bit y;
      bit v;
      bit b;
      bit d;
      int fc;
   } exp_t;

   typedef struct {
      logic [W-1:0] pat;
      int           rep;
      int           gap;
      int           abort_at;
      bit           noise;
      int           nvalid;
      logic [31:0]  ys;
      int           done_idx;
      int           ndone;
      int           fc;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   int          r_nvalid;
   logic [31:0] r_ys;
   int          r_done_idx;
   int          r_ndone;
   int          r_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack_dut();
      return {24'd0, y_o, valid_o, busy_o, done_o, frame_cnt_o};
   endfunction

   function automatic logic [31:0] pack_exp(exp_t e);
      return {24'd0, e.y, e.v, e.b, e.d, CNT_W'(e.fc)};
   endfunction

   // Reference trace: one entry per cycle after the accepting edge, built from
   // the frame/gap/done rules rather than from any state machine.
   task automatic run_xfer(input logic [W-1:0] pat, input int rep, input int gap,
                           input int abort_at, input bit noise);
      exp_t tr[$];
      exp_t e;
      int   nv;
      tr.delete();
      if (rep == 0) begin
         e = '{0, 0, 0, 1, 0};
         tr.push_back(e);
      end else begin
         for (int f = 0; f < rep; f++) begin
            for (int b = 0; b < W; b++) begin
               e = '{pat[W-1-b], 1, 1, 0, f};
               tr.push_back(e);
            end
            if (f < rep - 1) begin
               for (int g = 0; g < gap; g++) begin
                  e = '{0, 0, 1, 0, f + 1};
                  tr.push_back(e);
               end
            end
         end
         e = '{0, 0, 0, 1, rep};
         tr.push_back(e);
      end
      if (abort_at >= 0) begin
         nv = 0;
         for (int i = 0; i <= abort_at; i++) nv += tr[i].v;
         tr = tr[0:abort_at];
         e = '{0, 0, 0, 0, nv / W};
      end else begin
         e = '{0, 0, 0, 0, rep};
      end
      tr.push_back(e);
      tr.push_back(e);

      r_nvalid = 0; r_ys = '0; r_done_idx = -1; r_ndone = 0; r_fc = 0;
      @(negedge clk);
      start_i   = 1'b1;
      pattern_i = pat;
      repeats_i = CNT_W'(rep);
      gap_i     = GAP_W'(gap);
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int i = 0; i < tr.size(); i++) begin
         chk($sformatf("cycle%0d rep%0d gap%0d", i, rep, gap), pack_dut(), pack_exp(tr[i]));
         if (valid_o) begin
            r_nvalid++;
            r_ys = {r_ys[30:0], y_o};
         end
         if (done_o) begin
            if (r_done_idx < 0) r_done_idx = i;
            r_ndone++;
         end
         r_fc = int'(frame_cnt_o);
         abort_i = (i == abort_at);
         start_i = 1'b0;
         if (noise) begin
            pattern_i = '1;
            repeats_i = CNT_W'($urandom);
            gap_i     = GAP_W'($urandom);
            if (tr[i].b) start_i = 1'($urandom);
            if (!tr[i].b && i != abort_at) abort_i = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      abort_i = 1'b0;
   endtask

   vec_t tbl[6];

   initial begin
      int rep, gap, len, ab;
      logic [W-1:0] pat;

      tbl[0] = '{4'b1010, 1, 0, -1, 0,  4, 32'b1010,         4, 1, 1};
      tbl[1] = '{4'b1010, 3, 0, -1, 0, 12, 32'b101010101010, 12, 1, 3};
      tbl[2] = '{4'b1010, 2, 2, -1, 0,  8, 32'b10101010,     10, 1, 2};
      tbl[3] = '{4'b1010, 3, 0, -1, 1, 12, 32'b101010101010, 12, 1, 3};
      tbl[4] = '{4'b1010, 3, 0,  5, 0,  6, 32'b101010,       -1, 0, 1};
      tbl[5] = '{4'b1010, 0, 0, -1, 0,  0, 32'b0,             0, 1, 0};

      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      pattern_i = '0; repeats_i = '0; gap_i = '0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", pack_dut(), 32'd0);
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk); #1 chk("idle_after_reset", pack_dut(), 32'd0);

      for (int t = 0; t < 6; t++) begin
         run_xfer(tbl[t].pat, tbl[t].rep, tbl[t].gap, tbl[t].abort_at, tbl[t].noise);
         chk($sformatf("t%0d_nvalid", t),   r_nvalid,   tbl[t].nvalid);
         chk($sformatf("t%0d_ystream", t),  r_ys,       tbl[t].ys);
         chk($sformatf("t%0d_done_idx", t), r_done_idx, tbl[t].done_idx);
         chk($sformatf("t%0d_ndone", t),    r_ndone,    tbl[t].ndone);
         chk($sformatf("t%0d_frame_cnt", t), r_fc,      tbl[t].fc);
      end

      // Asynchronous reset while in GAP: outputs clear between clock edges.
      @(negedge clk);
      start_i = 1'b1; pattern_i = 4'b1100; repeats_i = 4'd2; gap_i = 4'd3;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("in_gap_before_reset", {30'd0, valid_o, busy_o}, 32'b01);
      #2 rst_ni = 1'b0;
      #1 chk("async_reset_mid_gap", pack_dut(), 32'd0);
      @(negedge clk) rst_ni = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("no_restart_after_reset", pack_dut(), 32'd0);

      for (int k = 0; k < 40; k++) begin
         pat = W'($urandom);
         rep = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
         gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
         len = (rep > 0) ? rep * W + (rep - 1) * gap : 0;
         ab  = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         run_xfer(pat, rep, gap, ab, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
